// File: rtl/alu_decoder.sv
// RV32I ALU-operation decoder with one registered output stage.
// Counts accepted illegal instructions in a saturating counter.
package alu_decoder_pkg;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } aluOperations;
endpackage

module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output aluOperations     out_op,
    output logic             out_use_imm,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        is_op, is_opimm, is_load, is_jalr, is_store;
    logic        is_lui, is_auipc, is_branch, is_jal;
    logic        accept;

    aluOperations d_op;
    logic         d_use;
    logic [31:0]  d_imm;
    logic         d_ill;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7],
                     instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12],
                     instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    assign is_op     = (opc == 7'b0110011);
    assign is_opimm  = (opc == 7'b0010011);
    assign is_load   = (opc == 7'b0000011);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_store  = (opc == 7'b0100011);
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_branch = (opc == 7'b1100011);
    assign is_jal    = (opc == 7'b1101111);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        d_op  = ALU_ADD;
        d_use = 1'b0;
        d_imm = 32'b0;
        d_ill = 1'b0;
        unique case (1'b1)
            is_op: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: d_op = ALU_ADD;
                        3'b001: d_op = ALU_SLL;
                        3'b010: d_op = ALU_SLT;
                        3'b011: d_op = ALU_SLTU;
                        3'b100: d_op = ALU_XOR;
                        3'b101: d_op = ALU_SRL;
                        3'b110: d_op = ALU_OR;
                        3'b111: d_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_op = ALU_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            is_opimm: begin
                d_use = 1'b1;
                d_imm = imm_i;
                case (f3)
                    3'b000: d_op = ALU_ADD;
                    3'b010: d_op = ALU_SLT;
                    3'b011: d_op = ALU_SLTU;
                    3'b100: d_op = ALU_XOR;
                    3'b110: d_op = ALU_OR;
                    3'b111: d_op = ALU_AND;
                    3'b001: begin
                        d_imm = imm_sh;
                        d_op  = ALU_SLL;
                        d_ill = (f7 != 7'b0000000);
                    end
                    3'b101: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000)
                            d_op = ALU_SRL;
                        else if (f7 == 7'b0100000)
                            d_op = ALU_SRA;
                        else
                            d_ill = 1'b1;
                    end
                endcase
            end
            is_load: begin
                d_use = 1'b1;
                d_imm = imm_i;
            end
            is_jalr: begin
                d_use = 1'b1;
                d_imm = imm_i;
                d_ill = (f3 != 3'b000);
            end
            is_store: begin
                d_use = 1'b1;
                d_imm = imm_s;
            end
            is_lui, is_auipc: begin
                d_use = 1'b1;
                d_imm = imm_u;
            end
            is_branch: begin
                d_imm = imm_b;
                case (f3)
                    3'b000, 3'b001: d_op = ALU_SUB;
                    3'b100, 3'b101: d_op = ALU_SLT;
                    3'b110, 3'b111: d_op = ALU_SLTU;
                    default:        d_ill = 1'b1;
                endcase
            end
            is_jal: begin
                d_use = 1'b1;
                d_imm = imm_j;
            end
            default: d_ill = 1'b1;
        endcase
        // illegal words present a clean, harmless ADD to the ALU
        if (d_ill) begin
            d_op  = ALU_ADD;
            d_use = 1'b0;
            d_imm = 32'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_op        <= ALU_ADD;
            out_use_imm   <= 1'b0;
            out_imm       <= 32'b0;
            out_illegal   <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= d_op;
            out_use_imm <= d_use;
            out_imm     <= d_imm;
            out_illegal <= d_ill;
            if (d_ill && illegal_count != CNT_MAX)
                illegal_count <= illegal_count + CNT_ONE;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: vector table, handshake
// corner cases and random stimulus against a reference model.
module tb_alu_decoder;
    import alu_decoder_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int ILL  = -1;

    // ops indexed by {funct7==0100000, funct3} for the OP opcode
    localparam int OP_TAB [16] = '{
        int'(ALU_ADD), int'(ALU_SLL), int'(ALU_SLT), int'(ALU_SLTU),
        int'(ALU_XOR), int'(ALU_SRL), int'(ALU_OR),  int'(ALU_AND),
        int'(ALU_SUB), ILL, ILL, ILL, ILL, int'(ALU_SRA), ILL, ILL
    };
    localparam int BR_TAB [8] = '{
        int'(ALU_SUB), int'(ALU_SUB), ILL, ILL,
        int'(ALU_SLT), int'(ALU_SLT), int'(ALU_SLTU), int'(ALU_SLTU)
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   instr = 32'b0;
    logic          in_ready;
    logic          out_valid;
    aluOperations  out_op;
    logic          out_use_imm;
    logic [31:0]   out_imm;
    logic          out_illegal;
    logic [CW-1:0] illegal_count;

    alu_decoder #(.CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr(instr),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op(out_op),
        .out_use_imm(out_use_imm),
        .out_imm(out_imm),
        .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit          m_valid = 0;
    int          m_op = int'(ALU_ADD);
    bit          m_use = 0;
    logic [31:0] m_imm = 0;
    bit          m_ill = 0;
    int          m_cnt = 0;

    typedef struct {
        logic [31:0]  instr;
        aluOperations op;
        bit           use_imm;
        logic [31:0]  imm;
        bit           ill;
        int           cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] i, output int op,
                                    output bit u, output logic [31:0] imm,
                                    output bit ill);
        int f3, f7, ii, bi, ji;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        ii = $signed(i) >>> 20;
        bi = (int'(i[11:8]) << 1) + (int'(i[30:25]) << 5)
           + (int'(i[7]) << 11) - (i[31] ? 4096 : 0);
        ji = (int'(i[30:21]) << 1) + (int'(i[20]) << 11)
           + (int'(i[19:12]) << 12) - (i[31] ? (1 << 20) : 0);
        op  = int'(ALU_ADD);
        u   = 0;
        imm = 0;
        ill = 0;
        case (i[6:0])
            7'h33: begin
                if (f7 == 0)       op = OP_TAB[f3];
                else if (f7 == 32) op = OP_TAB[8 + f3];
                else               op = ILL;
            end
            7'h13: begin
                u = 1;
                if (f3 == 1 || f3 == 5) begin
                    imm = 32'(i[24:20]);
                    if (f7 == 0)                 op = OP_TAB[f3];
                    else if (f7 == 32 && f3 == 5) op = int'(ALU_SRA);
                    else                          op = ILL;
                end else begin
                    op  = OP_TAB[f3];
                    imm = 32'(ii);
                end
            end
            7'h03: begin u = 1; imm = 32'(ii); end
            7'h67: begin
                u = 1; imm = 32'(ii);
                if (f3 != 0) op = ILL;
            end
            7'h23: begin u = 1; imm = 32'((ii & ~31) | int'(i[11:7])); end
            7'h37, 7'h17: begin u = 1; imm = i & 32'hFFFFF000; end
            7'h63: begin op = BR_TAB[f3]; imm = 32'(bi); end
            7'h6F: begin u = 1; imm = 32'(ji); end
            default: op = ILL;
        endcase
        if (op == ILL) ill = 1;
        if (ill) begin
            op = int'(ALU_ADD); u = 0; imm = 0;
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = int'(ALU_ADD); m_use = 0;
        m_imm = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic tick();
        int op; bit u; logic [31:0] im; bit il; bit rdy;
        #1;
        rdy = !m_valid || out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        ref_dec(instr, op, u, im, il);
        if (flush) begin
            m_valid = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_op = op; m_use = u; m_imm = im; m_ill = il;
            if (il && m_cnt < CMAX) m_cnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
        if (m_valid) begin
            chk("out_op", 32'(out_op), 32'(m_op));
            chk("out_use_imm", 32'(out_use_imm), 32'(m_use));
            chk("out_imm", out_imm, m_imm);
            chk("out_illegal", 32'(out_illegal), 32'(m_ill));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_op"}, 32'(out_op), 32'(ALU_ADD));
        chk({tag, "_use_imm"}, 32'(out_use_imm), 0);
        chk({tag, "_imm"}, out_imm, 0);
        chk({tag, "_illegal"}, 32'(out_illegal), 0);
        chk({tag, "_count"}, 32'(illegal_count), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  opcs [9];
        int k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                 7'h37, 7'h17, 7'h63, 7'h6F};
        i = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) i[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        tbl[0]  = '{32'h40208133, ALU_SUB,  1'b0, 32'h00000000, 1'b0, 0};
        tbl[1]  = '{32'hFFF00093, ALU_ADD,  1'b1, 32'hFFFFFFFF, 1'b0, 0};
        tbl[2]  = '{32'h4030D093, ALU_SRA,  1'b1, 32'h00000003, 1'b0, 0};
        tbl[3]  = '{32'h00000000, ALU_ADD,  1'b0, 32'h00000000, 1'b1, 1};
        tbl[4]  = '{32'h4020F0B3, ALU_ADD,  1'b0, 32'h00000000, 1'b1, 2};
        tbl[5]  = '{32'h123450B7, ALU_ADD,  1'b1, 32'h12345000, 1'b0, 2};
        tbl[6]  = '{32'hFE20AE23, ALU_ADD,  1'b1, 32'hFFFFFFFC, 1'b0, 2};
        tbl[7]  = '{32'hFE000CE3, ALU_SUB,  1'b0, 32'hFFFFFFF8, 1'b0, 2};
        tbl[8]  = '{32'h001000EF, ALU_ADD,  1'b1, 32'h00000800, 1'b0, 2};
        tbl[9]  = '{32'h00002063, ALU_ADD,  1'b0, 32'h00000000, 1'b1, 3};
        tbl[10] = '{32'h02101093, ALU_ADD,  1'b0, 32'h00000000, 1'b1, 4};
        tbl[11] = '{32'h00408067, ALU_ADD,  1'b1, 32'h00000004, 1'b0, 4};
        tbl[12] = '{32'hFFFFF097, ALU_ADD,  1'b1, 32'hFFFFF000, 1'b0, 4};
        tbl[13] = '{32'h003120B3, ALU_SLT,  1'b0, 32'h00000000, 1'b0, 4};
        tbl[14] = '{32'h00000010, ALU_ADD,  1'b0, 32'h00000000, 1'b1, 5};
        tbl[15] = '{32'h00505093, ALU_SRL,  1'b1, 32'h00000005, 1'b0, 5};

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        model_reset();

        // vector table, one accept per cycle with the consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (tbl[n]) begin
            instr = tbl[n].instr;
            tick();
            chk("tbl_valid", 32'(out_valid), 1);
            chk("tbl_op", 32'(out_op), 32'(tbl[n].op));
            chk("tbl_use_imm", 32'(out_use_imm), 32'(tbl[n].use_imm));
            chk("tbl_imm", out_imm, tbl[n].imm);
            chk("tbl_illegal", 32'(out_illegal), 32'(tbl[n].ill));
            chk("tbl_count", 32'(illegal_count), 32'(tbl[n].cnt));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        // backpressure: held result stays stable, then no-bubble replace
        in_valid = 1'b1;
        instr = 32'hFFF00093;
        tick();
        out_ready = 1'b0;
        instr = 32'h40208133;
        repeat (3) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_op", 32'(out_op), 32'(ALU_ADD));
            chk("bp_imm", out_imm, 32'hFFFFFFFF);
        end
        out_ready = 1'b1;
        tick();
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_op", 32'(out_op), 32'(ALU_SUB));
        in_valid = 1'b0;
        tick();

        // flush dominates an accept of an illegal word
        in_valid = 1'b1;
        instr = 32'h00000000;
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_count", 32'(illegal_count), 5);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();

        // asynchronous reset while a result is held under backpressure
        in_valid = 1'b1;
        instr = 32'h123450B7;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("arst_hold");
        rst_n = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        instr = 32'h4030D093;
        tick();
        chk("post_rst_op", 32'(out_op), 32'(ALU_SRA));

        // random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = rand_instr();
            tick();
        end
        flush = 1'b0;

        // saturation of the illegal counter
        in_valid = 1'b1;
        out_ready = 1'b1;
        instr = 32'h00000000;
        for (int n = 0; n < 40 && m_cnt < CMAX; n++) tick();
        tick();
        tick();
        chk("sat_count", 32'(illegal_count), 32'(CMAX));
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  instr holds a valid instruction word.
REQ-005 in_ready  output  1  decoder accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 flush  input  1  synchronous discard of the held output.
REQ-008 out_valid  output  1  decoded result is held.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_op  output  aluOperations  operation for the ALU: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT or SLTU.
REQ-011 out_use_imm  output  1  ALU data2 comes from out_imm rather than rs2.
REQ-012 out_imm  output  32  decoded immediate.
REQ-013 out_illegal  output  1  instruction not decodable.
REQ-014 illegal_count  output  CNT_W  number of illegal instructions accepted, saturating.

Function
REQ-015 One output register stage; in_ready = !out_valid || out_ready, combinational, with no dependence on in_valid.
REQ-016 Accept occurs when in_valid && in_ready. The decode loads on the next edge and out_valid=1, giving 1-cycle latency.
REQ-017 out_valid && !out_ready holds all out_* stable. A new accept and a drain in the same cycle replace the held result with no bubble.
REQ-018 out_valid clears on the edge after a drain with no accept.
REQ-019 flush=1 forces out_valid=0 on the next edge and dominates a simultaneous accept. in_ready stays per REQ-015, and an instruction accepted during flush is dropped.
REQ-020 OP (0110011), funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. With funct7 0100000: funct3 000 SUB, 101 SRA. Every other funct7/funct3 pair is illegal. use_imm=0, imm=0.
REQ-021 OP-IMM (0010011): 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, each with imm = sign-extended instr[31:20].
REQ-022 OP-IMM shifts: 001 with instr[31:25]=0000000 gives SLL; 101 with 0000000 gives SRL; 101 with 0100000 gives SRA. imm = zero-extended instr[24:20]. Any other instr[31:25] is illegal. use_imm=1 for all OP-IMM.
REQ-023 LOAD (0000011) and JALR (1100111, funct3 must be 000) decode to ADD, use_imm=1, I-immediate.
REQ-024 STORE (0100011) decodes to ADD, use_imm=1, S-immediate {instr[31:25],instr[11:7]} sign-extended.
REQ-025 LUI (0110111) and AUIPC (0010111) decode to ADD, use_imm=1, imm = {instr[31:12],12'b0}.
REQ-026 BRANCH (1100011): 000/001 SUB, 100/101 SLT, 110/111 SLTU. use_imm=0, imm = B-immediate sign-extended with bit 0 = 0. funct3 010/011 is illegal.
REQ-027 JAL (1101111) decodes to ADD, use_imm=1, imm = J-immediate sign-extended with bit 0 = 0.
REQ-028 instr[1:0] != 2'b11 or any other opcode is illegal.
REQ-029 An illegal instruction loads out_illegal=1, out_op=ADD, use_imm=0, imm=0. It still completes the handshake.
REQ-030 illegal_count increments by 1 per accepted illegal instruction that is not flushed. It holds at 2^CNT_W-1 with no wrap.

Reset
REQ-031 rst_n=0 asynchronously forces out_valid=0, out_op=ADD, out_use_imm=0, out_imm=0, out_illegal=0, illegal_count=0.
REQ-032 While rst_n=0, in_ready=1 per REQ-015 and no instruction is accepted.
REQ-033 Reset mid-handshake discards the held result. The first accept is permitted on the first rising edge with rst_n=1.

Verification
REQ-034 Accept instr 0x40208133 (sub) with out_ready=1: next cycle out_valid=1, out_op=SUB, use_imm=0, illegal=0.
REQ-035 Accept instr 0xFFF00093 (addi -1): out_op=ADD, use_imm=1, out_imm=0xFFFFFFFF. Accept 0x4030D093 (srai 3): out_op=SRA, out_imm=0x00000003.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles after an accept. out_* stay stable and in_ready=0. Then out_ready=1 with in_valid=1 gives back-to-back transfer with no bubble.
REQ-037 Stream 0x00000000 then 0x0020F0B3 with funct7 0100000 (0x4020F0B3). Each gives out_illegal=1, out_op=ADD, and illegal_count reaches 2. Force the count to 2^CNT_W-1; a further illegal instruction leaves it unchanged.
REQ-038 Assert flush in the same cycle as an accept of an illegal instr: out_valid=0 next cycle and illegal_count is unchanged.
REQ-039 Drop rst_n to 0 asynchronously while out_valid=1 and out_ready=0: all outputs take their REQ-031 values immediately, with no clock edge needed.
